// File: rtl/hack_boot_ctrl.sv
// HACK boot/run sequencer: byte-serial ROM load with CPU held in reset, then run with PC-loop halt detect.
// ROM write lands one cycle after the low byte is accepted; in_ready is registered and stays high while loading.
module hack_boot_ctrl #(
    parameter int ROM_DEPTH   = 32768,
    parameter int HALT_CYCLES = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        rom_we,
    output logic [14:0] rom_addr,
    output logic [15:0] rom_wdata,
    input  logic [14:0] pc,
    output logic        cpu_reset,
    output logic        running,
    output logic        halted,
    output logic        err,
    output logic [31:0] run_cycles
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_SETTLE,
        S_RUN,
        S_HALT,
        S_ERR
    } state_t;

    localparam logic [16:0] DEPTH_W = 17'(ROM_DEPTH);
    localparam int          MCW     = $clog2(HALT_CYCLES + 1);
    localparam logic [MCW-1:0] HALT_W = MCW'(HALT_CYCLES);

    state_t          state_q, state_d;
    logic [15:0]     len_q, len_d;
    logic [15:0]     idx_q, idx_d;
    logic [7:0]      hi_q, hi_d;
    logic            rom_we_q, rom_we_d;
    logic [14:0]     rom_addr_q, rom_addr_d;
    logic [15:0]     rom_wdata_q, rom_wdata_d;
    logic [14:0]     p1_q, p1_d;
    logic [14:0]     p2_q, p2_d;
    logic [1:0]      hist_q, hist_d;
    logic [MCW-1:0]  mcnt_q, mcnt_d;
    logic [31:0]     run_cycles_q, run_cycles_d;
    logic            in_ready_q, in_ready_d;
    logic            cpu_reset_q, cpu_reset_d;
    logic            running_q, running_d;
    logic            halted_q, halted_d;
    logic            err_q, err_d;

    logic            accept;
    logic            match;
    logic [15:0]     len_rx;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        idx_d        = idx_q;
        hi_d         = hi_q;
        rom_we_d     = 1'b0;
        rom_addr_d   = rom_addr_q;
        rom_wdata_d  = rom_wdata_q;
        p1_d         = p1_q;
        p2_d         = p2_q;
        hist_d       = 2'd0;
        mcnt_d       = '0;
        run_cycles_d = run_cycles_q;

        accept = in_valid && in_ready_q;
        len_rx = {len_q[15:8], in_data};
        // History needs two RUN cycles of pc before pc==p2 means anything.
        match  = (hist_q == 2'd2) && (pc == p2_q);

        case (state_q)
            S_IDLE, S_ERR, S_HALT: begin
                if (start) state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = in_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = in_data;
                    idx_d      = 16'd0;
                    if (len_rx == 16'd0)
                        state_d = S_SETTLE;
                    else if ({1'b0, len_rx} > DEPTH_W)
                        state_d = S_ERR;
                    else
                        state_d = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    hi_d    = in_data;
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (accept) begin
                    rom_we_d    = 1'b1;
                    rom_addr_d  = idx_q[14:0];
                    rom_wdata_d = {hi_q, in_data};
                    idx_d       = idx_q + 16'd1;
                    state_d     = (idx_q == len_q - 16'd1) ? S_SETTLE : S_DATA_HI;
                end
            end
            S_SETTLE: begin
                state_d      = S_RUN;
                run_cycles_d = 32'd0;
            end
            S_RUN: begin
                if (start) begin
                    state_d = S_LEN_HI;
                end else begin
                    if (run_cycles_q != 32'hFFFF_FFFF)
                        run_cycles_d = run_cycles_q + 32'd1;
                    p1_d   = pc;
                    p2_d   = p1_q;
                    hist_d = (hist_q == 2'd2) ? 2'd2 : hist_q + 2'd1;
                    if (match) begin
                        mcnt_d = mcnt_q + 1'b1;
                        if (mcnt_d == HALT_W) state_d = S_HALT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered from the next state so they are glitch-free flops.
        in_ready_d  = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                      (state_d == S_DATA_HI) || (state_d == S_DATA_LO);
        cpu_reset_d = !((state_d == S_RUN) || (state_d == S_HALT));
        running_d   = (state_d == S_RUN);
        halted_d    = (state_d == S_HALT);
        err_d       = (state_d == S_ERR);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_q        <= 16'd0;
            idx_q        <= 16'd0;
            hi_q         <= 8'd0;
            rom_we_q     <= 1'b0;
            rom_addr_q   <= 15'd0;
            rom_wdata_q  <= 16'd0;
            p1_q         <= 15'd0;
            p2_q         <= 15'd0;
            hist_q       <= 2'd0;
            mcnt_q       <= '0;
            run_cycles_q <= 32'd0;
            in_ready_q   <= 1'b0;
            cpu_reset_q  <= 1'b1;
            running_q    <= 1'b0;
            halted_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            hi_q         <= hi_d;
            rom_we_q     <= rom_we_d;
            rom_addr_q   <= rom_addr_d;
            rom_wdata_q  <= rom_wdata_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            hist_q       <= hist_d;
            mcnt_q       <= mcnt_d;
            run_cycles_q <= run_cycles_d;
            in_ready_q   <= in_ready_d;
            cpu_reset_q  <= cpu_reset_d;
            running_q    <= running_d;
            halted_q     <= halted_d;
            err_q        <= err_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign rom_we     = rom_we_q;
    assign rom_addr   = rom_addr_q;
    assign rom_wdata  = rom_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign running    = running_q;
    assign halted     = halted_q;
    assign err        = err_q;
    assign run_cycles = run_cycles_q;

endmodule
